// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared definitions for the data-memory load/store unit.
// Holds the memop encodings, FSM state encoding, the latched request payload
// and the memop -> access-size helper.
package dmem_lsu_pkg;

    localparam int unsigned MEM_BYTES_DEF = 4096;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned MEMOP_W_BITS  = 3;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_RD  = 3'd1,
        LD_CAP = 3'd2,
        ST_RD  = 3'd3,
        ST_WR  = 3'd4,
        RESP   = 3'd5
    } state_t;

    // Request fields that drive the memory port once latched.
    typedef struct packed {
        logic [ADDR_W-1:0]       addr;
        logic [DATA_W-1:0]       wdata;
        logic [MEMOP_W_BITS-1:0] memop;
    } mem_req_t;

    // Bytes touched by a memop; the sign bit (memop[2]) does not affect size.
    function automatic logic [2:0] access_size(input logic [2:0] memop);
        case (memop[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: core-side request/response handshake of the load/store unit.
//   req_*  : core -> LSU request (valid/ready), we, memop, addr, wdata
//   resp_* : LSU -> core response (valid/ready), data, err
// Modports: master = core side, slave = LSU side.
interface dmem_lsu_if;
    import dmem_lsu_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [MEMOP_W_BITS-1:0] req_memop;
    logic [ADDR_W-1:0]       req_addr;
    logic [DATA_W-1:0]       req_wdata;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_W-1:0]       resp_data;
    logic                    resp_err;

    modport master (
        output req_valid, req_we, req_memop, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_memop, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/dmem_lsu_chk.sv
// dmem_lsu_chk: combinational request legality check.
//   we, memop, addr : incoming request fields
//   err_c           : 1 = reject (illegal memop, out of range, or misaligned)
// Build option: DMEM_LSU_ALIGN_CHECK_EN adds halfword/word alignment errors.
module dmem_lsu_chk
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic                    we,
    input  logic [MEMOP_W_BITS-1:0] memop,
    input  logic [ADDR_W-1:0]       addr,
    output logic                    err_c
);

    logic        memop_bad;
    logic        range_bad;
    logic        align_bad;
    logic [32:0] end_addr;

    always_comb begin
        memop_bad = 1'b0;
        align_bad = 1'b0;
        case (memop)
            MEMOP_B, MEMOP_H, MEMOP_W: memop_bad = 1'b0;
            MEMOP_BU, MEMOP_HU:        memop_bad = we;
            default:                   memop_bad = 1'b1;
        endcase
        // 33-bit sum so addresses near 0xFFFFFFFF cannot wrap into range.
        end_addr  = {1'b0, addr} + 33'(access_size(memop));
        range_bad = end_addr > 33'(MEM_BYTES);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        align_bad = ((memop[1:0] == 2'b01) && addr[0]) ||
                    ((memop[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`endif
        err_c = memop_bad | range_bad | align_bad;
    end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit driving the data memory's byte-addressed port.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : core request/response handshake (dmem_lsu_if.slave)
//   mem_addr, mem_wdata, mem_memop, mem_we : registered memory port outputs
//   mem_rdata  : memory read data, valid the cycle after a read edge
// Build option: DMEM_LSU_ALIGN_CHECK_EN (see dmem_lsu_chk).
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    dmem_lsu_if.slave               bus,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [MEMOP_W_BITS-1:0] mem_memop,
    output logic                    mem_we,
    input  logic [DATA_W-1:0]       mem_rdata
);

    state_t            state_q, state_d;
    mem_req_t          req_q, req_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic              resp_valid_q;
    logic              req_ready_q;
    logic              mem_we_q;
    logic              chk_err_c;
    logic              accept_c;

    dmem_lsu_chk #(.MEM_BYTES(MEM_BYTES)) u_chk (
        .we    (bus.req_we),
        .memop (bus.req_memop),
        .addr  (bus.req_addr),
        .err_c (chk_err_c)
    );

    assign accept_c = (state_q == IDLE) && bus.req_valid && req_ready_q;

    // Next-state and next register values.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    req_d.addr  = bus.req_addr;
                    req_d.wdata = bus.req_wdata;
                    req_d.memop = bus.req_memop;
                    resp_data_d = '0;
                    resp_err_d  = chk_err_c;
                    if (chk_err_c)       state_d = RESP;
                    else if (bus.req_we) state_d = ST_RD;
                    else                 state_d = LD_RD;
                end
            end
            LD_RD:  state_d = LD_CAP;
            LD_CAP: begin
                resp_data_d = mem_rdata;
                state_d     = RESP;
            end
            ST_RD:  state_d = ST_WR;
            ST_WR:  state_d = RESP;
            RESP:   if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; flag outputs follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= (state_d == RESP);
            req_ready_q  <= (state_d == IDLE);
            mem_we_q     <= (state_d == ST_RD) || (state_d == ST_WR);
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;

    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_memop = req_q.memop;
    assign mem_we    = mem_we_q;

endmodule
